imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Boot-time program loader for the single-cycle core.
- Accepts a byte stream over a valid/ready handshake, packs it into little-endian 32-bit words and writes them sequentially into the instruction RAM write port.
- Holds the core in reset until the load completes, then releases it.
- After release, watches the core's writeback PC for a halt address and counts run cycles. This replaces hierarchical RAM preloading and PC polling in simulation, and serves as the on-board boot path.

Parameters:
- ADDR_W, 10, word-address width of the instruction RAM; capacity MAX_WORDS = 2**ADDR_W.
- HALT_PC, 32'h000000ff, writeback PC value that marks program end.

Ports:
- clk  input  1  system clock, rising edge.
- rstn  input  1  synchronous, active-low reset.
- in_valid  input  1  stream byte valid.
- in_data  input  8  stream byte.
- in_ready  output  1  loader can accept a byte.
- imem_we  output  1  instruction RAM write strobe, one cycle per word.
- imem_addr  output  ADDR_W  word address of the write.
- imem_wdata  output  32  word to write.
- core_rstn  output  1  active-low reset to the core; low until load completes.
- pc_w  input  32  core writeback PC.
- loaded_words  output  16  words written so far.
- run_cycles  output  32  cycles spent in RUN.
- halted  output  1  sticky; HALT_PC was reached.
- err  output  1  sticky; header word count exceeded MAX_WORDS.

Behaviour:
- Reset: synchronous, active-low, one clock; rstn is sampled at the rising edge of clk. While rstn=0:
  - state=CNT_LO;
  - in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0;
  - core_rstn=0, loaded_words=0, run_cycles=0, halted=0, err=0.
  - Byte index, word index and count register are cleared.
  - RAM contents are not touched.
- Stream format: count N as 2 bytes, low byte first; then 4*N instruction bytes, each word least-significant byte first.
- Handshake:
  - A byte transfers on a rising edge where in_valid=1 and in_ready=1.
  - in_ready=1 only in CNT_LO, CNT_HI and DATA; it is registered.
  - in_valid may drop at any time; gaps of any length are legal.
- States:
  - CNT_LO: on transfer, latch N[7:0]; go to CNT_HI.
  - CNT_HI: on transfer, latch N[15:8], then:
    - N=0: go to RELEASE;
    - N>MAX_WORDS: go to ERR;
    - otherwise go to DATA.
  - DATA: transfers fill bytes 0..3.
    - On the transfer of byte 3, in the next cycle imem_we=1, imem_addr=word index, imem_wdata={b3,b2,b1,b0}, and loaded_words increments.
    - After the write of word N-1, go to RELEASE.
    - Back-to-back words at full rate are supported: 4 transfer cycles per word, with no bubble inserted by the write.
  - RELEASE: one cycle with in_ready=0; core_rstn goes to 1 at the end of this cycle, i.e. one cycle after the final imem_we. Go to RUN.
  - RUN: core_rstn=1.
    - Each cycle with pc_w != HALT_PC: run_cycles increments, saturating at 32'hffffffff.
    - First cycle with pc_w == HALT_PC: no increment; go to HALT.
  - HALT: halted=1 (sticky); core_rstn stays 1; run_cycles frozen. Exits only on reset.
  - ERR: err=1, in_ready=0, core_rstn=0, no RAM writes. Exits only on reset.
- Write addresses: imem_addr sequence is 0,1,...,N-1. N=MAX_WORDS is legal and fills the RAM with no wrap.
- Reset mid-load: the partial word is discarded, and the stream must restart with a new header. Words already written remain in RAM.
- Extra bytes after the last word are not accepted (in_ready=0 from RELEASE onward).

Decomposition:
- Shared package imem_loader_pkg:
  - state enum {CNT_LO, CNT_HI, DATA, RELEASE, RUN, HALT, ERR};
  - HDR_BYTES=2;
  - BYTES_PER_WORD=4.
- One sub-module, byte_word_packer:
  - 2-bit byte index and 24-bit shift register;
  - emits word_valid plus a 32-bit word on the 4th byte;
  - cleared by rstn.
- The FSM, address counter, halt comparator and cycle counter stay in imem_loader.

Test Plan:
- Load N=3 with words 32'h00000293, 32'h00000313, 32'hFFFFF3B7 at full rate (bytes 03 00 93 02 00 00 ...) -> three imem_we pulses at addr 0,1,2 with exact data; loaded_words=3; core_rstn rises exactly 1 cycle after the third pulse.
- Same load with in_valid toggling 1/0 every cycle and random gaps -> identical write sequence; in_ready never high in RELEASE, RUN or ERR.
- Header N=0 -> no imem_we; core_rstn=1 two cycles after the CNT_HI transfer.
- Header N=MAX_WORDS+1 (1025 with ADDR_W=10) -> err=1, in_ready=0, core_rstn stays 0, no writes; a rstn pulse clears err.
- After load, drive pc_w=0,4,8 for 5 cycles, then 32'h000000ff -> run_cycles=5, halted=1 and held; further pc_w changes leave both unchanged.
- Assert rstn=0 for one cycle after 2 bytes of word 1 -> state CNT_LO, loaded_words=0, core_rstn=0; a fresh N=1 stream then writes addr 0 correctly.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction loader.
// Stream: 16-bit word count, then little-endian 32-bit words.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        CNT_LO,
        CNT_HI,
        DATA,
        RELEASE,
        RUN,
        HALT,
        ERR
    } state_t;

    localparam int HDR_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;

    function automatic logic is_rx_state(state_t s);
        return s inside {CNT_LO, CNT_HI, DATA};
    endfunction

endpackage

// File: rtl/byte_word_packer.sv
// Collects four stream bytes, least-significant first, into one word.
// The word and its strobe are registered, one cycle after byte 3.
import imem_loader_pkg::*;

module byte_word_packer (
    input  logic        clk,
    input  logic        rstn,
    input  logic        i_valid,
    input  logic [7:0]  i_data,
    output logic        o_last,
    output logic        o_word_valid,
    output logic [31:0] o_word
);

    localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_WORD - 1);

    logic [1:0]  r_idx;
    logic [23:0] r_shift;
    logic        r_word_valid;
    logic [31:0] r_word;

    assign o_last       = (r_idx == LAST_IDX);
    assign o_word_valid = r_word_valid;
    assign o_word       = r_word;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_idx        <= '0;
            r_shift      <= '0;
            r_word_valid <= 1'b0;
            r_word       <= '0;
        end else begin
            r_word_valid <= 1'b0;
            if (i_valid) begin
                if (r_idx == LAST_IDX) begin
                    r_word       <= {i_data, r_shift};
                    r_word_valid <= 1'b1;
                    r_idx        <= '0;
                end else begin
                    // newest byte enters at the top, so b0 ends at [7:0]
                    r_shift <= {i_data, r_shift[23:8]};
                    r_idx   <= r_idx + 2'd1;
                end
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: streams a program into instruction RAM, holds the core
// in reset until done, then counts run cycles until the halt PC.
import imem_loader_pkg::*;

module imem_loader #(
    parameter int          ADDR_W  = 10,
    parameter logic [31:0] HALT_PC = 32'h000000ff
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_rstn,
    input  logic [31:0]       pc_w,
    output logic [15:0]       loaded_words,
    output logic [31:0]       run_cycles,
    output logic              halted,
    output logic              err
);

    localparam logic [16:0]     MAXW = 17'(2 ** ADDR_W);
    localparam logic [ADDR_W:0] ONE  = {{ADDR_W{1'b0}}, 1'b1};

    state_t r_state;
    state_t w_next;

    logic [15:0]       r_cnt;
    logic [ADDR_W:0]   r_widx;
    logic [ADDR_W-1:0] r_addr;
    logic              r_in_ready;
    logic              r_core_rstn;
    logic [31:0]       r_run;
    logic              r_halted;
    logic              r_err;

    logic              w_xfer;
    logic              w_data_xfer;
    logic              w_pk_last;
    logic              w_word_done;
    logic              w_last_word;
    logic [15:0]       w_n_hdr;
    logic [ADDR_W:0]   w_widx_inc;
    logic              w_ready_nxt;
    logic              w_core_nxt;
    logic              w_pk_valid;
    logic [31:0]       w_pk_word;

    assign w_xfer      = in_valid & r_in_ready;
    assign w_data_xfer = w_xfer & (r_state == DATA);
    assign w_word_done = w_data_xfer & w_pk_last;
    assign w_n_hdr     = {in_data, r_cnt[7:0]};
    assign w_widx_inc  = r_widx + ONE;
    assign w_last_word = (16'(w_widx_inc) == r_cnt);

    byte_word_packer u_packer (
        .clk          (clk),
        .rstn         (rstn),
        .i_valid      (w_data_xfer),
        .i_data       (in_data),
        .o_last       (w_pk_last),
        .o_word_valid (w_pk_valid),
        .o_word       (w_pk_word)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= CNT_LO;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            CNT_LO: begin
                if (w_xfer) w_next = CNT_HI;
            end
            CNT_HI: begin
                if (w_xfer) begin
                    if (w_n_hdr == 16'd0) begin
                        w_next = RELEASE;
                    end else if ({1'b0, w_n_hdr} > MAXW) begin
                        w_next = ERR;
                    end else begin
                        w_next = DATA;
                    end
                end
            end
            DATA: begin
                // leave on the last byte so in_ready drops with the write
                if (w_word_done && w_last_word) w_next = RELEASE;
            end
            RELEASE: w_next = RUN;
            RUN: begin
                if (pc_w == HALT_PC) w_next = HALT;
            end
            HALT, ERR: w_next = r_state;
            default: w_next = CNT_LO;
        endcase
        w_ready_nxt = is_rx_state(w_next);
        w_core_nxt  = (w_next == RUN) || (w_next == HALT);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_cnt       <= '0;
            r_widx      <= '0;
            r_addr      <= '0;
            r_in_ready  <= 1'b0;
            r_core_rstn <= 1'b0;
            r_run       <= '0;
            r_halted    <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_in_ready  <= w_ready_nxt;
            r_core_rstn <= w_core_nxt;
            if (w_xfer && r_state == CNT_LO) r_cnt[7:0]  <= in_data;
            if (w_xfer && r_state == CNT_HI) r_cnt[15:8] <= in_data;
            if (w_word_done) begin
                r_addr <= r_widx[ADDR_W-1:0];
                r_widx <= w_widx_inc;
            end
            if (r_state == RUN && pc_w != HALT_PC && r_run != 32'hffffffff) begin
                r_run <= r_run + 32'd1;
            end
            if (w_next == HALT) r_halted <= 1'b1;
            if (w_next == ERR)  r_err    <= 1'b1;
        end
    end

    assign in_ready     = r_in_ready;
    assign imem_we      = w_pk_valid;
    assign imem_addr    = r_addr;
    assign imem_wdata   = w_pk_word;
    assign core_rstn    = r_core_rstn;
    assign loaded_words = 16'(r_widx);
    assign run_cycles   = r_run;
    assign halted       = r_halted;
    assign err          = r_err;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with a cycle-level reference model.
// Inputs change 1ns after rising edges; outputs are checked on falling edges.
module tb_imem_loader;

    localparam int          ADDR_W = 10;
    localparam int          MAXW   = 1 << ADDR_W;
    localparam logic [31:0] HPC    = 32'h000000ff;

    logic              clk = 1'b0;
    logic              rstn;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              core_rstn;
    logic [31:0]       pc_w;
    logic [15:0]       loaded_words;
    logic [31:0]       run_cycles;
    logic              halted;
    logic              err;

    imem_loader #(.ADDR_W(ADDR_W), .HALT_PC(HPC)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .core_rstn    (core_rstn),
        .pc_w         (pc_w),
        .loaded_words (loaded_words),
        .run_cycles   (run_cycles),
        .halted       (halted),
        .err          (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          addr;
        logic [31:0] data;
    } wr_t;

    int          errors = 0;
    int          checks = 0;
    int          cyc    = 0;
    bit          mon_en = 0;
    wr_t         exp_q[$];
    logic [31:0] wl[$];
    int          m_words, m_total, exp_rise;
    bit          no_ready, m_halt, m_err, m_core;
    logic [31:0] m_run;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            if (imem_we) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_we", 1, 0);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    chk("we_addr", 64'(imem_addr), 64'(e.addr));
                    chk("we_data", 64'(imem_wdata), 64'(e.data));
                    m_words++;
                    if (m_words == m_total) begin
                        exp_rise = cyc + 1;
                        no_ready = 1;
                    end
                end
            end
            m_core = (exp_rise >= 0) && (cyc >= exp_rise);
            chk("loaded_words", 64'(loaded_words), 64'(m_words));
            chk("core_rstn", 64'(core_rstn), 64'(m_core));
            chk("run_cycles", 64'(run_cycles), 64'(m_run));
            chk("halted", 64'(halted), 64'(m_halt));
            chk("err", 64'(err), 64'(m_err));
            if (no_ready) chk("in_ready_idle", 64'(in_ready), 0);
            if (m_core && !m_halt) begin
                if (pc_w == HPC) m_halt = 1;
                else if (m_run != 32'hffffffff) m_run = m_run + 1;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        step(1);
        exp_q.delete();
        m_words  = 0;
        m_total  = 0;
        exp_rise = -1;
        no_ready = 0;
        m_halt   = 0;
        m_err    = 0;
        m_run    = 0;
        rstn     = 1'b1;
        mon_en   = 1;
        chk("rst_in_ready", 64'(in_ready), 0);
        chk("rst_we", 64'(imem_we), 0);
        chk("rst_addr", 64'(imem_addr), 0);
        chk("rst_wdata", 64'(imem_wdata), 0);
        chk("rst_core", 64'(core_rstn), 0);
        chk("rst_words", 64'(loaded_words), 0);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit rdy;
        in_valid = 1'b0;
        step(gap);
        in_valid = 1'b1;
        in_data  = b;
        for (int t = 0; ; t++) begin
            if (t > 200) begin
                chk("ready_timeout", 0, 1);
                break;
            end
            rdy = in_ready;
            step(1);
            if (rdy) break;
        end
        in_valid = 1'b0;
    endtask

    function automatic int gap_of(input int gm, input int k);
        if (gm == 0) return 0;
        if (k % 2 == 0) return 1;
        return int'($urandom_range(0, 3));
    endfunction

    task automatic send_hdr(input int n, input int gm);
        logic [15:0] nn;
        nn = 16'(n);
        send_byte(nn[7:0], gap_of(gm, 0));
        send_byte(nn[15:8], gap_of(gm, 1));
        if (n == 0) begin
            exp_rise = cyc + 1;
            no_ready = 1;
        end else if (n > MAXW) begin
            m_err    = 1;
            no_ready = 1;
        end
    endtask

    task automatic load(input int n, input int gm);
        m_total = n;
        for (int i = 0; i < n; i++) exp_q.push_back('{addr: i, data: wl[i]});
        send_hdr(n, gm);
        for (int i = 0; i < n; i++) begin
            for (int b = 0; b < 4; b++) begin
                send_byte(8'(wl[i] >> (8 * b)), gap_of(gm, 4 * i + b));
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn     = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        pc_w     = HPC;
        step(2);
        do_reset();

        wl = '{32'h00000293, 32'h00000313, 32'hFFFFF3B7};
        load(3, 0);
        pc_w = 32'h0;
        chk("t1_last_we", 64'(imem_we), 1);
        chk("t1_last_addr", 64'(imem_addr), 2);
        chk("t1_last_data", 64'(imem_wdata), 64'h00000000FFFFF3B7);
        chk("t1_core_low", 64'(core_rstn), 0);
        step(1);
        chk("t1_core_high", 64'(core_rstn), 1);
        for (int k = 0; k < 5; k++) begin
            pc_w = 32'(4 * k);
            step(1);
        end
        pc_w = HPC;
        step(1);
        for (int k = 0; k < 4; k++) begin
            pc_w = 32'h40 + 32'(4 * k);
            step(1);
        end
        chk("t5_run", 64'(run_cycles), 5);
        chk("t5_halted", 64'(halted), 1);
        chk("t1_words", 64'(loaded_words), 3);
        pc_w = HPC;

        do_reset();
        load(3, 1);
        step(5);
        chk("t2_words", 64'(loaded_words), 3);
        chk("t2_core", 64'(core_rstn), 1);

        do_reset();
        send_hdr(0, 0);
        step(3);
        chk("t3_core", 64'(core_rstn), 1);
        chk("t3_words", 64'(loaded_words), 0);

        do_reset();
        send_hdr(MAXW + 1, 0);
        in_valid = 1'b1;
        in_data  = 8'h5a;
        step(6);
        in_valid = 1'b0;
        chk("t4_err", 64'(err), 1);
        chk("t4_ready", 64'(in_ready), 0);
        chk("t4_core", 64'(core_rstn), 0);
        do_reset();
        chk("t4_err_clr", 64'(err), 0);

        wl.delete();
        for (int i = 0; i < MAXW; i++) wl.push_back(32'(i) * 32'h9E3779B1 ^ 32'h5A000000);
        load(MAXW, 0);
        step(4);
        chk("tmax_words", 64'(loaded_words), 64'(MAXW));
        chk("tmax_err", 64'(err), 0);
        chk("tmax_core", 64'(core_rstn), 1);

        do_reset();
        wl = '{32'h11223344, 32'h55667788};
        m_total = 2;
        exp_q.push_back('{addr: 0, data: wl[0]});
        send_hdr(2, 0);
        for (int b = 0; b < 4; b++) send_byte(8'(wl[0] >> (8 * b)), 0);
        send_byte(8'h88, 0);
        send_byte(8'h77, 0);
        step(1);
        chk("t6_pre_words", 64'(loaded_words), 1);
        do_reset();
        chk("t6_core", 64'(core_rstn), 0);
        step(1);
        chk("t6_ready_back", 64'(in_ready), 1);
        wl = '{32'hCAFEF00D};
        load(1, 0);
        step(3);
        chk("t6_words", 64'(loaded_words), 1);

        chk("exp_q_empty", 64'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
